// File: rtl/fetch_redirect_unit.sv
// PC owner and instruction fetcher: one outstanding imem request, valid/ready handoff to decode,
// redirects squash stale fetches. Optional build macro: MISALIGN_CHECK_EN.
module fetch_redirect_unit #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            iCLK,
   input  logic            iRST_N,
   input  logic            iREDIR_VALID,
   input  logic [PC_W-1:0] iREDIR_PC,
   output logic            oIMEM_REQ,
   output logic [PC_W-1:0] oIMEM_ADDR,
   input  logic            iIMEM_GNT,
   input  logic            iIMEM_RVALID,
   input  logic [31:0]     iIMEM_RDATA,
   output logic            oIR_VALID,
   output logic [31:0]     oIR,
   output logic [PC_W-1:0] oPC,
   input  logic            iIR_READY,
`ifdef MISALIGN_CHECK_EN
   output logic            oMISALIGN,
`endif
   output logic [1:0]      dbgState
);

   // Handshakes: a transfer happens on a rising edge where valid (oIMEM_REQ / oIR_VALID) and the
   // matching ready (iIMEM_GNT / iIR_READY) are both high; valid never depends on ready.
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

   localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

   state_t          state, stateNext;
   logic [PC_W-1:0] pc, pcNext;
   logic            discard, discardNext;
   logic [31:0]     irReg, irNext;
   logic [PC_W-1:0] pcOutReg, pcOutNext;
   logic            redirTake;
   logic [PC_W-1:0] redirTarget;

`ifdef MISALIGN_CHECK_EN
   logic misalignReg;
   logic misalignNext;

   // A misaligned target is rejected outright; only the one-cycle flag records it.
   assign redirTake    = iREDIR_VALID && (iREDIR_PC[1:0] == 2'b00);
   assign misalignNext = iREDIR_VALID && (iREDIR_PC[1:0] != 2'b00);
   assign redirTarget  = iREDIR_PC;
   assign oMISALIGN    = misalignReg;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) misalignReg <= 1'b0;
      else         misalignReg <= misalignNext;
   end
`else
   assign redirTake   = iREDIR_VALID;
   assign redirTarget = iREDIR_PC & ALIGN_MASK;
`endif

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         discard  <= 1'b0;
         irReg    <= 32'd0;
         pcOutReg <= RESET_PC;
      end else begin
         state    <= stateNext;
         pc       <= pcNext;
         discard  <= discardNext;
         irReg    <= irNext;
         pcOutReg <= pcOutNext;
      end
   end

   always_comb begin
      stateNext   = state;
      pcNext      = pc;
      discardNext = discard;
      irNext      = irReg;
      pcOutNext   = pcOutReg;
      case (state)
         S_IDLE: stateNext = S_REQ;
         S_REQ: begin
            if (iIMEM_GNT) begin
               stateNext = S_WAIT;
               // The granted request still carries the old address; its reply must be dropped.
               if (redirTake) discardNext = 1'b1;
            end
         end
         S_WAIT: begin
            if (iIMEM_RVALID) begin
               if (discard || redirTake) begin
                  discardNext = 1'b0;
                  stateNext   = S_REQ;
               end else begin
                  irNext    = iIMEM_RDATA;
                  pcOutNext = pc;
                  pcNext    = pc + PC_W'(4);
                  stateNext = S_OUT;
               end
            end else if (redirTake) begin
               discardNext = 1'b1;
            end
         end
         S_OUT: begin
            if (redirTake || iIR_READY) stateNext = S_REQ;
         end
         default: stateNext = S_IDLE;
      endcase
      // Redirect overrides any sequential update; the latest one wins.
      if (redirTake) pcNext = redirTarget;
   end

   always_comb begin
      oIMEM_REQ = 1'b0;
      oIR_VALID = 1'b0;
      case (state)
         S_REQ:   oIMEM_REQ = 1'b1;
         S_OUT:   oIR_VALID = 1'b1;
         default: ;
      endcase
   end

   assign oIMEM_ADDR = pc;
   assign oIR        = irReg;
   assign oPC        = pcOutReg;
   assign dbgState   = state;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed table-driven bench for fetch_redirect_unit; follows MISALIGN_CHECK_EN when defined.
module tb_fetch_redirect_unit;
   localparam int PC_W = 8;

   logic            iCLK;
   logic            iRST_N;
   logic            iREDIR_VALID;
   logic [PC_W-1:0] iREDIR_PC;
   logic            oIMEM_REQ;
   logic [PC_W-1:0] oIMEM_ADDR;
   logic            iIMEM_GNT;
   logic            iIMEM_RVALID;
   logic [31:0]     iIMEM_RDATA;
   logic            oIR_VALID;
   logic [31:0]     oIR;
   logic [PC_W-1:0] oPC;
   logic            iIR_READY;
   logic [1:0]      dbgState;
`ifdef MISALIGN_CHECK_EN
   logic            oMISALIGN;
`endif

   fetch_redirect_unit #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N),
      .iREDIR_VALID(iREDIR_VALID), .iREDIR_PC(iREDIR_PC),
      .oIMEM_REQ(oIMEM_REQ), .oIMEM_ADDR(oIMEM_ADDR),
      .iIMEM_GNT(iIMEM_GNT), .iIMEM_RVALID(iIMEM_RVALID), .iIMEM_RDATA(iIMEM_RDATA),
      .oIR_VALID(oIR_VALID), .oIR(oIR), .oPC(oPC), .iIR_READY(iIR_READY),
`ifdef MISALIGN_CHECK_EN
      .oMISALIGN(oMISALIGN),
`endif
      .dbgState(dbgState)
   );

   // clock / reset
   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   typedef struct {
      logic        rv;
      logic [7:0]  rpc;
      logic        gnt;
      logic        rvl;
      logic [31:0] rd;
      logic        rdy;
      logic        eReq;
      logic [7:0]  eAddr;
      logic        eVal;
      logic [31:0] eIr;
      logic [7:0]  ePc;
   } vec_t;

   vec_t vecs[$];
   int   nCmp = 0;
   int   nBad = 0;
   logic [7:0] expRedir;

   task automatic addRow(input logic rv, input logic [7:0] rpc, input logic gnt, input logic rvl,
                         input logic [31:0] rd, input logic rdy, input logic eReq,
                         input logic [7:0] eAddr, input logic eVal, input logic [31:0] eIr,
                         input logic [7:0] ePc);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.gnt = gnt; v.rvl = rvl; v.rd = rd; v.rdy = rdy;
      v.eReq = eReq; v.eAddr = eAddr; v.eVal = eVal; v.eIr = eIr; v.ePc = ePc;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rv, input logic [7:0] rpc, input logic gnt, input logic rvl,
                        input logic [31:0] rd, input logic rdy);
      iREDIR_VALID = rv; iREDIR_PC = rpc; iIMEM_GNT = gnt;
      iIMEM_RVALID = rvl; iIMEM_RDATA = rd; iIR_READY = rdy;
   endtask

   task automatic chkOut(input string tag, input logic eReq, input logic [7:0] eAddr,
                         input logic eVal, input logic [31:0] eIr, input logic [7:0] ePc);
      chk({tag, ".req"},  32'(oIMEM_REQ),  32'(eReq));
      chk({tag, ".addr"}, 32'(oIMEM_ADDR), 32'(eAddr));
      chk({tag, ".val"},  32'(oIR_VALID),  32'(eVal));
      chk({tag, ".ir"},   oIR,             eIr);
      chk({tag, ".pc"},   32'(oPC),        32'(ePc));
   endtask

   initial begin
      // rows: rv rpc gnt rvl rdata rdy | req addr val ir pc
      addRow(0, 0, 0, 0, 0, 0,             0, 8'h00, 0, 32'h0, 8'h00);          // idle
      addRow(0, 0, 1, 0, 0, 0,             1, 8'h00, 0, 32'h0, 8'h00);
      addRow(0, 0, 0, 1, 32'hA0000000, 0,  0, 8'h00, 0, 32'h0, 8'h00);
      addRow(0, 0, 0, 0, 0, 1,             0, 8'h04, 1, 32'hA0000000, 8'h00);
      addRow(0, 0, 1, 0, 0, 0,             1, 8'h04, 0, 32'hA0000000, 8'h00);
      addRow(0, 0, 0, 1, 32'hA0000004, 0,  0, 8'h04, 0, 32'hA0000000, 8'h00);
      addRow(0, 0, 0, 0, 0, 1,             0, 8'h08, 1, 32'hA0000004, 8'h04);
      addRow(0, 0, 1, 0, 0, 0,             1, 8'h08, 0, 32'hA0000004, 8'h04);
      addRow(0, 0, 0, 1, 32'hA0000008, 0,  0, 8'h08, 0, 32'hA0000004, 8'h04);
      for (int i = 0; i < 5; i++)                                               // decode stalls
         addRow(0, 0, 0, 0, 0, 0,          0, 8'h0C, 1, 32'hA0000008, 8'h08);
      addRow(0, 0, 0, 0, 0, 1,             0, 8'h0C, 1, 32'hA0000008, 8'h08);
      addRow(1, 8'h40, 1, 0, 0, 0,         1, 8'h0C, 0, 32'hA0000008, 8'h08);   // redirect on grant
      addRow(0, 0, 0, 1, 32'hDEAD000C, 0,  0, 8'h40, 0, 32'hA0000008, 8'h08);   // stale data
      addRow(0, 0, 0, 0, 0, 0,             1, 8'h40, 0, 32'hA0000008, 8'h08);
      addRow(0, 0, 1, 0, 0, 0,             1, 8'h40, 0, 32'hA0000008, 8'h08);
      addRow(0, 0, 0, 0, 0, 0,             0, 8'h40, 0, 32'hA0000008, 8'h08);
      addRow(0, 0, 0, 1, 32'hA0000040, 0,  0, 8'h40, 0, 32'hA0000008, 8'h08);
      addRow(0, 0, 0, 0, 0, 1,             0, 8'h44, 1, 32'hA0000040, 8'h40);
      addRow(0, 0, 1, 0, 0, 0,             1, 8'h44, 0, 32'hA0000040, 8'h40);
      addRow(1, 8'h20, 0, 0, 0, 0,         0, 8'h44, 0, 32'hA0000040, 8'h40);   // two redirects in wait
      addRow(1, 8'h30, 0, 0, 0, 0,         0, 8'h20, 0, 32'hA0000040, 8'h40);
      addRow(0, 0, 0, 1, 32'hDEAD0044, 0,  0, 8'h30, 0, 32'hA0000040, 8'h40);
      addRow(0, 0, 1, 0, 0, 0,             1, 8'h30, 0, 32'hA0000040, 8'h40);
      addRow(0, 0, 0, 1, 32'hA0000030, 0,  0, 8'h30, 0, 32'hA0000040, 8'h40);
      addRow(0, 0, 0, 0, 0, 1,             0, 8'h34, 1, 32'hA0000030, 8'h30);
      addRow(0, 0, 1, 0, 0, 0,             1, 8'h34, 0, 32'hA0000030, 8'h30);
      addRow(0, 0, 0, 1, 32'hA0000034, 0,  0, 8'h34, 0, 32'hA0000030, 8'h30);
      addRow(1, 8'hFC, 0, 0, 0, 0,         0, 8'h38, 1, 32'hA0000034, 8'h34);   // redirect in out
      addRow(0, 0, 1, 0, 0, 0,             1, 8'hFC, 0, 32'hA0000034, 8'h34);
      addRow(0, 0, 0, 1, 32'hA00000FC, 0,  0, 8'hFC, 0, 32'hA0000034, 8'h34);
      addRow(0, 0, 0, 0, 0, 1,             0, 8'h00, 1, 32'hA00000FC, 8'hFC);   // wrap
      addRow(0, 0, 1, 0, 0, 0,             1, 8'h00, 0, 32'hA00000FC, 8'hFC);
      addRow(0, 0, 0, 1, 32'hB0000000, 0,  0, 8'h00, 0, 32'hA00000FC, 8'hFC);
      addRow(0, 0, 0, 0, 0, 1,             0, 8'h04, 1, 32'hB0000000, 8'h00);
      addRow(0, 0, 0, 0, 0, 0,             1, 8'h04, 0, 32'hB0000000, 8'h00);

      iRST_N = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge iCLK);
      chkOut("reset", 0, 8'h00, 0, 32'h0, 8'h00);
`ifdef MISALIGN_CHECK_EN
      chk("reset.misalign", 32'(oMISALIGN), 32'd0);
`endif
      iRST_N = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].rv, vecs[i].rpc, vecs[i].gnt, vecs[i].rvl, vecs[i].rd, vecs[i].rdy);
         chkOut($sformatf("row%0d", i), vecs[i].eReq, vecs[i].eAddr, vecs[i].eVal,
                vecs[i].eIr, vecs[i].ePc);
         @(negedge iCLK);
      end

      // rvalid while requesting is ignored
      drive(0, 0, 0, 1, 32'hDEADBEEF, 0);
      chkOut("rvIgn0", 1, 8'h04, 0, 32'hB0000000, 8'h00);
      @(negedge iCLK);
      // misaligned redirect
      drive(1, 8'h42, 0, 0, 0, 0);
      chkOut("rvIgn1", 1, 8'h04, 0, 32'hB0000000, 8'h00);
      @(negedge iCLK);
`ifdef MISALIGN_CHECK_EN
      expRedir = 8'h04;
      chk("mis.pulse", 32'(oMISALIGN), 32'd1);
`else
      expRedir = 8'h40;
`endif
      drive(0, 0, 1, 0, 0, 0);
      chkOut("mis.req", 1, expRedir, 0, 32'hB0000000, 8'h00);
      @(negedge iCLK);
`ifdef MISALIGN_CHECK_EN
      chk("mis.clear", 32'(oMISALIGN), 32'd0);
`endif
      drive(0, 0, 0, 1, 32'hC0000000, 0);
      chkOut("mis.wait", 0, expRedir, 0, 32'hB0000000, 8'h00);
      @(negedge iCLK);
      drive(0, 0, 0, 0, 0, 1);
      chkOut("mis.out", 0, expRedir + 8'h04, 1, 32'hC0000000, expRedir);
      @(negedge iCLK);
      drive(0, 0, 1, 0, 0, 0);
      chkOut("mid.req", 1, expRedir + 8'h04, 0, 32'hC0000000, expRedir);
      @(negedge iCLK);

      // reset while waiting, then a late rvalid after release
      drive(0, 0, 0, 0, 0, 0);
      iRST_N = 1'b0;
      #1;
      chkOut("midRst", 0, 8'h00, 0, 32'h0, 8'h00);
      @(negedge iCLK);
      iRST_N = 1'b1;
      drive(0, 0, 0, 1, 32'hDEADBEEF, 0);
      chkOut("late0", 0, 8'h00, 0, 32'h0, 8'h00);
      @(negedge iCLK);
      drive(0, 0, 0, 0, 0, 0);
      chkOut("late1", 1, 8'h00, 0, 32'h0, 8'h00);
      @(negedge iCLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
